// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed RAM plus a 16-word IO page (LED, TIMER, WCOUNT, STATUS)
// Every edge registers one read; writes are write-first.
module mem_responder #(
    parameter int unsigned ADDR_BITS = 12,
    parameter logic [15:0] IO_BASE   = 16'hFFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic [15:0] wdata,
    input  logic        wr,
    output logic [15:0] rdata,
    output logic [7:0]  leds,
    output logic        led_strobe,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, WRITE, STROBE} state_t;

    logic [15:0] mem [2**ADDR_BITS];

    state_t      state_q, state_d;
    logic [15:0] rdata_q, rdata_d;
    logic [7:0]  leds_q, leds_d;
    logic        bus_err_q, bus_err_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] wcount_q, wcount_d;

    logic        ram_hit, io_hit, unmapped;
    logic [15:0] io_diff;
    logic [3:0]  io_off;
    logic        ram_we, led_we, timer_we, wcount_we, status_we;
    logic [15:0] rd_val;

    // RAM wins any overlap with the IO page when ADDR_BITS is large.
    always_comb begin
        ram_hit  = ({16'b0, address} < (32'd1 << ADDR_BITS));
        io_diff  = address - IO_BASE;
        io_hit   = !ram_hit && (address >= IO_BASE) && (io_diff[15:4] == 12'd0);
        io_off   = io_diff[3:0];
        unmapped = !ram_hit && !io_hit;
    end

    always_comb begin
        ram_we    = wr && ram_hit;
        led_we    = wr && io_hit && (io_off == 4'd0);
        timer_we  = wr && io_hit && (io_off == 4'd1);
        wcount_we = wr && io_hit && (io_off == 4'd2);
        status_we = wr && io_hit && (io_off == 4'd3);
    end

    always_comb begin
        rd_val = 16'h0000;
        if (ram_hit) begin
            rd_val = mem[address[ADDR_BITS-1:0]];
        end else if (io_hit) begin
            case (io_off)
                4'd0:    rd_val = {8'h00, leds_q};
                4'd1:    rd_val = timer_q;
                4'd2:    rd_val = wcount_q;
                4'd3:    rd_val = {15'b0, bus_err_q};
                default: rd_val = 16'h0000;
            endcase
        end
    end

    always_comb begin
        rdata_d = unmapped ? 16'h0000 : (wr ? wdata : rd_val);
        leds_d  = led_we ? wdata[7:0] : leds_q;
        timer_d = timer_we ? wdata : timer_q + 16'd1;

        wcount_d = wcount_q;
        if (wcount_we) begin
            wcount_d = 16'h0000;
        end else if (ram_we && (wcount_q != 16'hFFFF)) begin
            wcount_d = wcount_q + 16'd1;
        end

        // A set in the same cycle as a STATUS clear must survive.
        bus_err_d = unmapped || (bus_err_q && !(status_we && wdata[0]));
    end

    always_comb begin
        state_d = IDLE;
        if (led_we) begin
            state_d = STROBE;
        end else if (wr) begin
            state_d = WRITE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && ram_we) begin
            mem[address[ADDR_BITS-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rdata_q   <= 16'h0000;
            leds_q    <= 8'h00;
            bus_err_q <= 1'b0;
            timer_q   <= 16'h0000;
            wcount_q  <= 16'h0000;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            leds_q    <= leds_d;
            bus_err_q <= bus_err_d;
            timer_q   <= timer_d;
            wcount_q  <= wcount_d;
        end
    end

    assign rdata      = rdata_q;
    assign leds       = leds_q;
    assign led_strobe = (state_q == STROBE);
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic [15:0] address;
    logic [15:0] wdata;
    logic        wr;
    logic [15:0] rdata;
    logic [7:0]  leds;
    logic        led_strobe;
    logic        bus_err;

    int n_cmp;
    int n_err;

    mem_responder #(.ADDR_BITS(12), .IO_BASE(16'hFFF0)) dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .wdata      (wdata),
        .wr         (wr),
        .rdata      (rdata),
        .leds       (leds),
        .led_strobe (led_strobe),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        rst     = r;
        wr      = w;
        address = a;
        wdata   = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; wr = 1'b0; address = 16'h0000; wdata = 16'h0000;

        cyc(1, 0, 16'h0000, 16'h0000);
        cyc(1, 0, 16'h0000, 16'h0000);
        check("reset_rdata", rdata, 16'h0000);
        check("reset_leds", {8'h00, leds}, 16'h0000);
        check("reset_strobe", {15'b0, led_strobe}, 16'h0000);
        check("reset_bus_err", {15'b0, bus_err}, 16'h0000);

        // Write-first and WCOUNT after a single RAM write
        cyc(0, 1, 16'h0010, 16'hBEEF);
        check("wr_first_beef", rdata, 16'hBEEF);
        cyc(0, 0, 16'hFFF2, 16'h0000);
        check("wcount_one", rdata, 16'h0001);

        // Write then read back
        cyc(0, 1, 16'h0005, 16'h1234);
        check("wr_first_1234", rdata, 16'h1234);
        cyc(0, 0, 16'h0010, 16'h0000);
        check("read_0010", rdata, 16'hBEEF);
        cyc(0, 0, 16'h0005, 16'h0000);
        check("read_0005", rdata, 16'h1234);

        // LED write and one-cycle strobe
        cyc(0, 1, 16'hFFF0, 16'h00A5);
        check("led_value", {8'h00, leds}, 16'h00A5);
        check("led_strobe_hi", {15'b0, led_strobe}, 16'h0001);
        cyc(0, 0, 16'hFFF0, 16'h0000);
        check("led_strobe_lo", {15'b0, led_strobe}, 16'h0000);
        check("led_readback", rdata, 16'h00A5);

        // Back-to-back LED writes keep the strobe up
        cyc(0, 1, 16'hFFF0, 16'h123C);
        check("led_b2b_1", {15'b0, led_strobe}, 16'h0001);
        cyc(0, 1, 16'hFFF0, 16'h00C3);
        check("led_b2b_2", {15'b0, led_strobe}, 16'h0001);
        check("led_b2b_val", {8'h00, leds}, 16'h00C3);
        cyc(0, 0, 16'h0000, 16'h0000);
        check("led_b2b_end", {15'b0, led_strobe}, 16'h0000);

        // wr held three edges counts three writes
        cyc(0, 1, 16'h0020, 16'h1111);
        cyc(0, 1, 16'h0020, 16'h1111);
        cyc(0, 1, 16'h0020, 16'h1111);
        cyc(0, 0, 16'hFFF2, 16'h0000);
        check("wcount_five", rdata, 16'h0005);
        cyc(0, 0, 16'h0020, 16'h0000);
        check("read_0020", rdata, 16'h1111);
        cyc(0, 1, 16'hFFF2, 16'h7777);
        cyc(0, 0, 16'hFFF2, 16'h0000);
        check("wcount_clear", rdata, 16'h0000);

        // TIMER load and wrap
        cyc(0, 1, 16'hFFF1, 16'hFFFE);
        check("timer_wr_first", rdata, 16'hFFFE);
        cyc(0, 0, 16'hFFF1, 16'h0000);
        check("timer_loaded", rdata, 16'hFFFE);
        cyc(0, 0, 16'hFFF1, 16'h0000);
        check("timer_ffff", rdata, 16'hFFFF);
        cyc(0, 0, 16'hFFF1, 16'h0000);
        check("timer_wrap", rdata, 16'h0000);

        // Reserved IO offsets
        cyc(0, 1, 16'hFFF5, 16'h4444);
        cyc(0, 0, 16'hFFF5, 16'h0000);
        check("io_rsvd_rd", rdata, 16'h0000);
        check("io_rsvd_noerr", {15'b0, bus_err}, 16'h0000);

        // Unmapped access: zero data, sticky error, no RAM alias write
        cyc(0, 1, 16'h0000, 16'hAAAA);
        cyc(0, 0, 16'h8000, 16'h0000);
        check("unmapped_rd", rdata, 16'h0000);
        check("unmapped_err", {15'b0, bus_err}, 16'h0001);
        cyc(0, 1, 16'h1000, 16'h5555);
        check("unmapped_wr_rd", rdata, 16'h0000);
        cyc(0, 0, 16'h0000, 16'h0000);
        check("no_alias_wr", rdata, 16'hAAAA);
        check("err_sticky", {15'b0, bus_err}, 16'h0001);
        cyc(0, 0, 16'hFFF3, 16'h0000);
        check("status_rd", rdata, 16'h0001);
        cyc(0, 1, 16'hFFF3, 16'h0001);
        check("status_clear", {15'b0, bus_err}, 16'h0000);

        // Reset during a write, with leds and bus_err non-zero beforehand
        cyc(0, 0, 16'h9000, 16'h0000);
        check("err_pre_rst", {15'b0, bus_err}, 16'h0001);
        cyc(1, 1, 16'h0020, 16'hDEAD);
        check("rst_rdata", rdata, 16'h0000);
        check("rst_leds", {8'h00, leds}, 16'h0000);
        check("rst_strobe", {15'b0, led_strobe}, 16'h0000);
        check("rst_bus_err", {15'b0, bus_err}, 16'h0000);
        cyc(0, 0, 16'h0020, 16'h0000);
        check("rst_wr_suppressed", rdata, 16'h1111);
        cyc(0, 0, 16'hFFF2, 16'h0000);
        check("rst_wcount", rdata, 16'h0000);
        cyc(0, 0, 16'hFFF1, 16'h0000);
        check("rst_timer_run", rdata, 16'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 12, giving the RAM word-address width (RAM depth 2**ADDR_BITS 16-bit words).
REQ-002 The block SHALL have parameter IO_BASE, default 16'hFFF0, giving the first word address of the 16-word IO page.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port address, input, 16 bits: word address driven by the CPU.
REQ-006 The block SHALL have port wdata, input, 16 bits: write data (the CPU's data_out).
REQ-007 The block SHALL have port wr, input, 1 bit: write enable, sampled each rising edge.
REQ-008 The block SHALL have port rdata, output, 16 bits: registered read data (the CPU's data_in).
REQ-009 The block SHALL have port leds, output, 8 bits: LED latch.
REQ-010 The block SHALL have port led_strobe, output, 1 bit: one-cycle pulse on each LED write.
REQ-011 The block SHALL have port bus_err, output, 1 bit: sticky out-of-range access flag.

Function
REQ-012 Address decode SHALL be: address < 2**ADDR_BITS -> RAM; IO_BASE <= address <= IO_BASE+15 -> IO page; all other addresses -> unmapped.
REQ-013 Every edge, rdata SHALL load the read value of the address sampled at that edge: one-cycle read latency, no handshake, and a read on every cycle regardless of wr.
REQ-014 When wr=1 and the address is in RAM, that word SHALL take wdata at the edge.
REQ-015 When wr=1, rdata at that same edge SHALL load wdata, i.e. write-first read-during-write.
REQ-016 IO offset 0 (LED): a write SHALL set leds to wdata[7:0] and pulse led_strobe high for exactly the following cycle; a read SHALL return {8'h00, leds}.
REQ-017 IO offset 1 (TIMER): a free-running 16-bit cycle counter SHALL increment every non-reset cycle and wrap 16'hFFFF -> 16'h0000; a write SHALL load wdata, with the increment resuming on the next cycle; a read SHALL return the pre-increment value at the sampling edge.
REQ-018 IO offset 2 (WCOUNT): a 16-bit counter SHALL count accepted RAM writes and saturate at 16'hFFFF; any write to offset 2 SHALL clear it, and the clear SHALL take priority over a count in the same cycle.
REQ-019 IO offset 3 (STATUS): a read SHALL return {15'b0, bus_err}; a write with wdata[0]=1 SHALL clear bus_err.
REQ-020 IO offsets 4-15 SHALL read 16'h0000, ignore writes, and not set bus_err.
REQ-021 Any access (read or write) to an unmapped address SHALL set bus_err, SHALL return rdata 16'h0000, and SHALL not alter RAM or IO state.
REQ-022 If bus_err is set by an access in the same cycle as a STATUS clear, the set SHALL win.
REQ-023 A wr level held across N consecutive edges SHALL be treated as N writes, and each write SHALL count in WCOUNT.
REQ-024 The internal states SHALL be IDLE (wr=0), WRITE (wr=1 edge) and STROBE (led_strobe high). STROBE SHALL last exactly one cycle and SHALL re-enter if another LED write occurs during it.

Reset
REQ-025 While rst=1 at an edge, the block SHALL set rdata=0, leds=0, led_strobe=0, bus_err=0, TIMER=0 and WCOUNT=0, and SHALL ignore wr.
REQ-026 RAM contents SHALL not be cleared by reset.
REQ-027 Reset asserted during a write SHALL suppress that write.
REQ-028 The first edge after rst deasserts SHALL behave as a normal cycle.

Verification
REQ-029 Write 16'h1234 to 16'h0005, then read 16'h0005 -> rdata=16'h1234 one cycle after the read address edge.
REQ-030 wr=1, address 16'h0010, wdata 16'hBEEF -> rdata=16'hBEEF at the same edge, and WCOUNT reads 1.
REQ-031 Write 16'h00A5 to 16'hFFF0 -> leds=8'hA5 and led_strobe high for exactly one cycle.
REQ-032 Write 16'hFFFE to 16'hFFF1, then read on consecutive cycles -> rdata 16'hFFFF, then 16'h0000 (wrap).
REQ-033 Read 16'h8000 -> rdata=16'h0000 and bus_err=1; write 16'h0001 to 16'hFFF3 -> bus_err=0.
REQ-034 Assert rst with wr=1 at 16'h0020 -> RAM[0x20] unchanged, and all outputs 0 on the next cycle.
